kernel_bank_buffer: RTL and testbench
=====================================

// Module: kernel_bank_buffer
// PURPOSE
//  Double-banked weight buffer between the weight stream and the PE array.
//  - Loads one kernel set (NUM_K kernels x TAPS taps) word-by-word into a shadow bank.
//  - Presents the active bank to the PEs as a flat parallel bus.
//  - Swaps banks on PE release, so the next set loads while the current one is in use.
// PARAMETERS
//  DATA_W  16  signed weight word width
//  TAPS     9  taps per kernel (3x3)
//  NUM_K    4  kernels presented in parallel
// PORTS
//  clk         in   1                    clock
//  rst         in   1                    reset, asynchronous, active-high
//  s_valid     in   1                    weight word valid
//  s_ready     out  1                    buffer can accept a word (= !shadow_full)
//  s_data      in   DATA_W               signed weight word
//  flush       in   1                    sync: discard partial/full shadow contents
//  pe_release  in   1                    1-cycle pulse: PEs finished with active set
//  k_valid     out  1                    active bank holds a valid kernel set
//  k_out       out  NUM_K*TAPS*DATA_W    active weights; kernel k tap t at [(k*TAPS+t)*DATA_W +: DATA_W]
//  fill_count  out  $clog2(TOTAL+1)      words currently in shadow bank
//  bias_out    out  NUM_K*DATA_W         (only with KBUF_BIAS_EN) kernel k bias at [k*DATA_W +: DATA_W]
// BEHAVIOUR
//  - TOTAL = NUM_K*TAPS (NUM_K*(TAPS+1) with KBUF_BIAS_EN).
//  - Reset: both banks 0, bank select 0, fill_count 0, shadow_full 0, k_valid 0, k_out 0, s_ready 1.
//  - Load:
//    - Word accepted on a clk edge with s_valid & s_ready.
//    - Word n is written to shadow[n] (kernel n/TAPS, tap n%TAPS); kernel 0 tap 0 first.
//    - fill_count increments by 1 per accepted word.
//    - No shifting: a write touches only its own slot.
//  - Loader FSM: FILL -> FULL when the TOTAL-th word is accepted.
//    - In FULL: shadow_full=1 and s_ready=0; s_valid is ignored.
//    - FULL -> FILL on swap or flush.
//  - Swap condition (sampled at a clk edge): state==FULL & !flush & (!k_valid | pe_release).
//    - On swap: bank select toggles, k_valid<=1, fill_count<=0, state<=FILL.
//    - k_out/bias_out come from registered bank storage via bank-select mux only.
//    - The new set is visible in the same cycle that k_valid rises.
//  - Latency with k_valid=0: last word accepted at edge E -> swap at E+1 -> k_valid=1 after E+1.
//    - s_ready returns to 1 after E+1.
//  - pe_release while state==FILL: k_valid<=0. The old set stays on k_out; it is not cleared.
//    - The swap then occurs automatically one edge after the shadow fills.
//  - pe_release while k_valid=0: ignored.
//  - pe_release on the same edge the last word is accepted:
//    - Treated as release-while-FILL: k_valid<=0.
//    - Swap follows at the next edge.
//  - flush: fill_count<=0, state<=FILL.
//    - Shadow data is not cleared; slots are overwritten on reload.
//    - Active bank and k_valid are untouched.
//    - flush and swap in the same cycle: flush wins, no swap.
//    - flush overrides a word accepted in the same cycle; that word is dropped.
//  - Reset mid-load or mid-use: everything returns to reset values immediately (async).
//  - Data is stored and output bit-exact; no sign extension or arithmetic.
// CONFIGURATION
//  KBUF_BIAS_EN defined:
//    - Each kernel group is TAPS+1 words; the last word of the group is that kernel's bias.
//    - Bias words are stored in a separate shadow/active bias bank that swaps with the weight banks.
//    - bias_out port exists.
//  KBUF_BIAS_EN undefined:
//    - Groups are TAPS words; no bias storage; bias_out port absent.
// TESTING (defaults, KBUF_BIAS_EN off unless noted)
//  1. Reset, stream words 1..36 with s_valid held 1 ->
//     - s_ready=0 after word 36; k_valid=1 one edge later.
//     - k_out kernel0 tap0=1, kernel3 tap8=36.
//  2. Load set A (1..36), then set B (101..136) with no release ->
//     - B fills, s_ready=0, fill_count=36, k_out still A.
//     - pe_release pulse -> next edge k_out kernel0 tap0=101, fill_count=0.
//  3. Release while B half-loaded (fill_count=18) ->
//     - k_valid=0, k_out still A.
//     - After word 136 accepted, k_valid=1 one edge later with B.
//  4. Load 20 words, assert flush, then load 201..236 ->
//     - fill_count=0 after flush.
//     - Swap yields kernel0 tap0=201; active set unchanged before the swap.
//  5. Shadow FULL with flush and pe_release in the same cycle ->
//     - No swap; k_out unchanged; fill_count=0; s_ready=1.
//  6. Assert rst mid-load (fill_count=10) and mid-use ->
//     - All outputs 0, k_valid=0, s_ready=1 without waiting for a clk edge.
//  7. KBUF_BIAS_EN: stream 40 words, groups of 10 (9 weights + bias) ->
//     - k_valid after word 40; bias_out kernel0 = word 10, kernel3 = word 40.

Source files
------------

// File: rtl/kernel_bank_buffer_if.sv
// kernel_bank_buffer_if: weight word stream handshake.
// Signals: s_valid (word valid), s_ready (sink can accept), s_data (weight word).
// master drives valid/data, slave drives ready.
interface kernel_bank_buffer_if #(
    parameter int DATA_W = 16
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );
endinterface

// File: rtl/kernel_bank_buffer.sv
// kernel_bank_buffer: double-banked weight buffer; loads a kernel set into the
// shadow bank while the active bank is presented to the PEs, swaps on release.
// Ports: clk, rst (async, active-high), stream (slave: s_valid/s_ready/s_data),
//   flush (discard shadow), pe_release (active set done), k_valid, k_out,
//   fill_count (words in shadow), bias_out (only with KBUF_BIAS_EN).
// Option: define KBUF_BIAS_EN to append a bias word to every kernel group.
module kernel_bank_buffer #(
    parameter  int DATA_W = 16,
    parameter  int TAPS   = 9,
    parameter  int NUM_K  = 4,
`ifdef KBUF_BIAS_EN
    localparam int GRP    = TAPS + 1,
`else
    localparam int GRP    = TAPS,
`endif
    localparam int TOTAL  = NUM_K * GRP,
    localparam int CW     = $clog2(TOTAL + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    kernel_bank_buffer_if.slave           stream,
    input  logic                          flush,
    input  logic                          pe_release,
    output logic                          k_valid,
    output logic [NUM_K*TAPS*DATA_W-1:0]  k_out,
    output logic [CW-1:0]                 fill_count
`ifdef KBUF_BIAS_EN
    ,
    output logic [NUM_K*DATA_W-1:0]       bias_out
`endif
);

    localparam int NW = NUM_K * TAPS;
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic {
        FILL,
        FULL
    } state_t;

    state_t state;
    state_t state_nx;

    logic              bank_sel;
    logic              accept;
    logic              last;
    logic              swap;
    logic              wr_en;
    logic [IW-1:0]     w_ptr;
    logic [DATA_W-1:0] w_mem [2][NW];

`ifdef KBUF_BIAS_EN
    localparam int KW = (NUM_K > 1) ? $clog2(NUM_K) : 1;
    localparam int TW = $clog2(GRP);

    logic [KW-1:0]     k_idx;
    logic [TW-1:0]     t_idx;
    logic              is_bias;
    logic [DATA_W-1:0] b_mem [2][NUM_K];

    assign is_bias = (t_idx == TW'(TAPS));
`endif

    assign stream.s_ready = (state == FILL);
    assign accept = stream.s_valid & stream.s_ready;
    assign last   = accept & (fill_count == CW'(TOTAL - 1));
    // flush beats swap; a pending set waits for release only while k_valid
    assign swap   = (state == FULL) & ~flush & (~k_valid | pe_release);
    assign wr_en  = accept & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FILL;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            FILL: if (last && !flush) state_nx = FULL;
            FULL: if (flush || swap)  state_nx = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_sel   <= 1'b0;
            k_valid    <= 1'b0;
            fill_count <= '0;
            w_ptr      <= '0;
`ifdef KBUF_BIAS_EN
            k_idx      <= '0;
            t_idx      <= '0;
`endif
        end else begin
            // release during FILL drops the set; k_out keeps old data
            if (swap) begin
                bank_sel <= ~bank_sel;
                k_valid  <= 1'b1;
            end else if (pe_release && state == FILL) begin
                k_valid  <= 1'b0;
            end

            if (flush || swap) begin
                fill_count <= '0;
                w_ptr      <= '0;
`ifdef KBUF_BIAS_EN
                k_idx      <= '0;
                t_idx      <= '0;
`endif
            end else if (accept) begin
                fill_count <= fill_count + CW'(1);
`ifdef KBUF_BIAS_EN
                if (is_bias) begin
                    t_idx <= '0;
                    k_idx <= k_idx + KW'(1);
                end else begin
                    t_idx <= t_idx + TW'(1);
                    w_ptr <= w_ptr + IW'(1);
                end
`else
                w_ptr <= w_ptr + IW'(1);
`endif
            end
        end
    end

    // shadow bank is always the one not selected for output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < NW; i++) w_mem[b][i] <= '0;
            end
        end else if (wr_en) begin
`ifdef KBUF_BIAS_EN
            if (!is_bias) w_mem[~bank_sel][w_ptr] <= stream.s_data;
`else
            w_mem[~bank_sel][w_ptr] <= stream.s_data;
`endif
        end
    end

    for (genvar g = 0; g < NW; g++) begin : g_kout
        assign k_out[g*DATA_W +: DATA_W] = w_mem[bank_sel][g];
    end

`ifdef KBUF_BIAS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < NUM_K; i++) b_mem[b][i] <= '0;
            end
        end else if (wr_en && is_bias) begin
            b_mem[~bank_sel][k_idx] <= stream.s_data;
        end
    end

    for (genvar g = 0; g < NUM_K; g++) begin : g_bias
        assign bias_out[g*DATA_W +: DATA_W] = b_mem[bank_sel][g];
    end
`endif

endmodule

// File: tb/tb_kernel_bank_buffer.sv
// tb_kernel_bank_buffer: directed scenarios plus random traffic against a
// queue-based model of the shadow/active kernel sets.
module tb_kernel_bank_buffer;

    localparam int DW    = 16;
    localparam int TAPS  = 9;
    localparam int NK    = 4;
`ifdef KBUF_BIAS_EN
    localparam int GRP   = TAPS + 1;
`else
    localparam int GRP   = TAPS;
`endif
    localparam int TOTAL = NK * GRP;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int VW    = NK * TAPS * DW;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              pe_release;
    logic              k_valid;
    logic [VW-1:0]     k_out;
    logic [CW-1:0]     fill_count;
`ifdef KBUF_BIAS_EN
    logic [NK*DW-1:0]  bias_out;
`endif

    kernel_bank_buffer_if #(.DATA_W(DW)) sif ();

    kernel_bank_buffer #(
        .DATA_W(DW),
        .TAPS  (TAPS),
        .NUM_K (NK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stream    (sif),
        .flush     (flush),
        .pe_release(pe_release),
        .k_valid   (k_valid),
        .k_out     (k_out),
        .fill_count(fill_count)
`ifdef KBUF_BIAS_EN
        ,
        .bias_out  (bias_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_act [TOTAL];
    bit            m_full;
    bit            m_kv;

    task automatic chk(input string tag, input logic [VW-1:0] got,
                       input logic [VW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [VW-1:0] exp_kout();
        logic [VW-1:0] r = '0;
        for (int n = 0; n < TOTAL; n++) begin
            int k = n / GRP;
            int p = n % GRP;
            if (p < TAPS) r[(k*TAPS+p)*DW +: DW] = m_act[n];
        end
        return r;
    endfunction

`ifdef KBUF_BIAS_EN
    function automatic logic [NK*DW-1:0] exp_bias();
        logic [NK*DW-1:0] r = '0;
        for (int k = 0; k < NK; k++) r[k*DW +: DW] = m_act[k*GRP + TAPS];
        return r;
    endfunction
`endif

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < TOTAL; i++) m_act[i] = '0;
        m_full = 0;
        m_kv   = 0;
    endtask

    task automatic model_edge(input bit v, input logic [DW-1:0] d,
                              input bit fl, input bit rel);
        bit acc = v && !m_full;
        bit sw  = m_full && !fl && (!m_kv || rel);
        if (rel && !m_full) m_kv = 0;
        if (fl) begin
            m_q.delete();
            m_full = 0;
        end else if (sw) begin
            for (int i = 0; i < TOTAL; i++) m_act[i] = m_q[i];
            m_q.delete();
            m_full = 0;
            m_kv   = 1;
        end else if (acc) begin
            m_q.push_back(d);
            if (m_q.size() == TOTAL) m_full = 1;
        end
    endtask

    task automatic check_all();
        chk("s_ready", sif.s_ready, !m_full);
        chk("k_valid", k_valid, m_kv);
        chk("fill_count", fill_count, m_q.size());
        chk("k_out", k_out, exp_kout());
`ifdef KBUF_BIAS_EN
        chk("bias_out", bias_out, exp_bias());
`endif
    endtask

    task automatic step(input bit v, input logic [DW-1:0] d,
                        input bit fl, input bit rel);
        sif.s_valid = v;
        sif.s_data  = d;
        flush       = fl;
        pe_release  = rel;
        @(posedge clk);
        model_edge(v, d, fl, rel);
        @(negedge clk);
        check_all();
    endtask

    task automatic load(input int base, input int n);
        for (int i = 0; i < n; i++) step(1, DW'(base + i), 0, 0);
    endtask

    // reset lands between clock edges; outputs must clear before the next edge
    task automatic areset();
        sif.s_valid = 0;
        flush       = 0;
        pe_release  = 0;
        #2 rst = 1;
        #1;
        model_reset();
        check_all();
        chk("rst_k0t0", k_out[DW-1:0], 0);
        chk("rst_ready", sif.s_ready, 1);
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        rst         = 1;
        sif.s_valid = 0;
        sif.s_data  = '0;
        flush       = 0;
        pe_release  = 0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst = 0;

        // 1: first set, swaps one edge after fill; s_valid ignored when full
        load(1, TOTAL);
        chk("t1_ready", sif.s_ready, 0);
        step(1, 16'd999, 0, 0);
        chk("t1_kv", k_valid, 1);
        chk("t1_k0t0", k_out[DW-1:0], 1);
        chk("t1_k3t8", k_out[(3*TAPS+8)*DW +: DW], 3*GRP + 9);

        // 2: second set waits for release
        load(101, TOTAL);
        chk("t2_ready", sif.s_ready, 0);
        chk("t2_fill", fill_count, TOTAL);
        chk("t2_hold", k_out[DW-1:0], 1);
        step(0, 0, 0, 1);
        chk("t2_k0t0", k_out[DW-1:0], 101);
        chk("t2_fill0", fill_count, 0);

        // 3: release while half-loaded
        load(301, TOTAL / 2);
        step(0, 0, 0, 1);
        chk("t3_kv0", k_valid, 0);
        chk("t3_hold", k_out[DW-1:0], 101);
        load(301 + TOTAL / 2, TOTAL - TOTAL / 2);
        chk("t3_kv_late", k_valid, 0);
        step(0, 0, 0, 0);
        chk("t3_kv1", k_valid, 1);
        chk("t3_k0t0", k_out[DW-1:0], 301);

        // 4: flush a partial load, reload
        load(501, 20);
        step(0, 0, 1, 0);
        chk("t4_fill0", fill_count, 0);
        load(201, TOTAL);
        chk("t4_hold", k_out[DW-1:0], 301);
        step(0, 0, 0, 1);
        chk("t4_k0t0", k_out[DW-1:0], 201);

        // 5: flush and release together on a full shadow
        load(401, TOTAL);
        step(0, 0, 1, 1);
        chk("t5_kv", k_valid, 1);
        chk("t5_k0t0", k_out[DW-1:0], 201);
        chk("t5_fill", fill_count, 0);
        chk("t5_ready", sif.s_ready, 1);

        // 6: async reset mid-load and mid-use
        load(601, 10);
        areset();
        load(1, TOTAL);
        step(0, 0, 0, 0);
        load(701, 5);
        areset();

`ifdef KBUF_BIAS_EN
        // 7: groups of 9 weights + bias
        load(1, TOTAL);
        step(0, 0, 0, 0);
        chk("t7_kv", k_valid, 1);
        chk("t7_b0", bias_out[DW-1:0], 10);
        chk("t7_b3", bias_out[3*DW +: DW], 40);
`endif

        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                areset();
            end else begin
                step($urandom_range(0, 9) < 7, DW'($urandom),
                     $urandom_range(0, 59) == 0,
                     $urandom_range(0, 14) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
